// File: rtl/checkerboard_state_reader_if.sv
// Output beat stream of the checkerboard state reader: one (x, y, state) cell per beat.
interface checkerboard_state_reader_if #(
    parameter int DATA_BITS      = 2,
    parameter int EDGE_ADDR_BITS = 3
);
    logic                      valid;
    logic                      ready;
    logic [EDGE_ADDR_BITS-1:0] x;
    logic [EDGE_ADDR_BITS-1:0] y;
    logic [DATA_BITS-1:0]      data;
    logic                      last;

    modport master (output valid, x, y, data, last, input ready);
    modport slave  (input valid, x, y, data, last, output ready);
endinterface

// File: rtl/checkerboard_state_reader.sv
// Raster-order reader of the checkerboard state RAM, streaming every cell on a valid/ready beat.
// Define CHECKERBOARD_READER_COUNT_EN to build the per-scan black/white stone tally.
//
// state | meaning
// IDLE  | waiting for start; idx parked at 0
// SCAN  | loading one cell per accepted (or empty) output slot
// DRAIN | last cell loaded, waiting for its beat to be accepted
module checkerboard_state_reader #(
    parameter int DATA_BITS      = 2,
    parameter int EDGE_ADDR_BITS = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic [2*EDGE_ADDR_BITS-1:0]     rd_addr,
    input  logic [DATA_BITS-1:0]            rd_data,
    checkerboard_state_reader_if.master     beat,
    output logic [2*EDGE_ADDR_BITS:0]       cnt_black,
    output logic [2*EDGE_ADDR_BITS:0]       cnt_white
);
    localparam int E  = EDGE_ADDR_BITS;
    localparam int AW = 2 * E;
    localparam int CW = 2 * E + 1;
    localparam logic [AW-1:0] IDX_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_nxt;
    logic [AW-1:0]        idx_q, idx_nxt;
    logic                 busy_q, busy_nxt;
    logic                 done_q, done_nxt;
    logic                 valid_q, valid_nxt;
    logic [E-1:0]         x_q, x_nxt;
    logic [E-1:0]         y_q, y_nxt;
    logic [DATA_BITS-1:0] data_q, data_nxt;
    logic                 last_q, last_nxt;
    logic                 load;
    logic                 clr_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            valid_q <= valid_nxt;
            x_q     <= x_nxt;
            y_q     <= y_nxt;
            data_q  <= data_nxt;
            last_q  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        valid_nxt = valid_q;
        x_nxt     = x_q;
        y_nxt     = y_q;
        data_nxt  = data_q;
        last_nxt  = last_q;
        load      = 1'b0;
        clr_cnt   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_nxt   = '0;
                    busy_nxt  = 1'b1;
                    clr_cnt   = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                // Output slot is free when empty or being drained this cycle.
                load = !valid_q || beat.ready;
                if (load) begin
                    data_nxt  = rd_data;
                    x_nxt     = idx_q[E-1:0];
                    y_nxt     = idx_q[AW-1:E];
                    last_nxt  = (idx_q == IDX_MAX);
                    valid_nxt = 1'b1;
                    idx_nxt   = idx_q + 1'b1;
                    if (idx_q == IDX_MAX) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (valid_q && beat.ready) begin
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rd_addr    = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign beat.valid = valid_q;
    assign beat.x     = x_q;
    assign beat.y     = y_q;
    assign beat.data  = data_q;
    assign beat.last  = last_q;

`ifdef CHECKERBOARD_READER_COUNT_EN
    logic [CW-1:0] black_q;
    logic [CW-1:0] white_q;

    // Reserved state 3 and empty cells fall through both compares.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            black_q <= '0;
            white_q <= '0;
        end else if (clr_cnt) begin
            black_q <= '0;
            white_q <= '0;
        end else if (load) begin
            if (rd_data == DATA_BITS'(1)) begin
                black_q <= black_q + 1'b1;
            end
            if (rd_data == DATA_BITS'(2)) begin
                white_q <= white_q + 1'b1;
            end
        end
    end

    assign cnt_black = black_q;
    assign cnt_white = white_q;
`else
    logic unused_cnt_ctrl;

    assign unused_cnt_ctrl = load ^ clr_cnt;
    assign cnt_black       = '0;
    assign cnt_white       = '0;
`endif

endmodule

// File: tb/tb_checkerboard_state_reader.sv
// Scoreboard bench for checkerboard_state_reader: RAM model, expected-beat queue, beat monitor.
module tb_checkerboard_state_reader;
    localparam int E  = 3;
    localparam int DB = 2;
    localparam int N  = 1 << (2 * E);
    localparam int W  = 1 << E;
    localparam int CW = 2 * E + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done;
    logic [2*E-1:0] rd_addr;
    logic [DB-1:0] rd_data;
    logic [CW-1:0] cnt_black, cnt_white;
    logic [DB-1:0] ram [N];

    checkerboard_state_reader_if #(.DATA_BITS(DB), .EDGE_ADDR_BITS(E)) sif ();

    checkerboard_state_reader #(.DATA_BITS(DB), .EDGE_ADDR_BITS(E)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .beat      (sif.master),
        .cnt_black (cnt_black),
        .cnt_white (cnt_white)
    );

    assign rd_data = ram[rd_addr];

    always #5 clk = ~clk;

    typedef struct packed {
        logic [E-1:0]  x;
        logic [E-1:0]  y;
        logic [DB-1:0] d;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    beats_acc = 0;
    int    done_cnt = 0;
    bit    mon_en = 1'b0;
    bit    rand_ready = 1'b0;
    bit    ready_fixed = 1'b0;
    bit    stall_pend = 1'b0;
    beat_t stall_b;
    beat_t cur_b;
    beat_t exp_b;
    int    exp_black, exp_white;

    task automatic check_eq(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        sif.ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            sif.ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!mon_en) begin
            stall_pend = 1'b0;
        end else if (sif.valid) begin
            cur_b = {sif.x, sif.y, sif.data, sif.last};
            if (stall_pend) check_eq("stall_payload_hold", cur_b, stall_b);
            if (sif.ready) begin
                stall_pend = 1'b0;
                beats_acc++;
                check_eq("beat_expected", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_b = exp_q.pop_front();
                    check_eq("beat_x", cur_b.x, exp_b.x);
                    check_eq("beat_y", cur_b.y, exp_b.y);
                    check_eq("beat_data", cur_b.d, exp_b.d);
                    check_eq("beat_last", cur_b.last, exp_b.last);
                end
            end else begin
                stall_pend = 1'b1;
                stall_b    = cur_b;
            end
        end else begin
            stall_pend = 1'b0;
        end
    end

    task automatic load_model();
        exp_black = 0;
        exp_white = 0;
        for (int i = 0; i < N; i++) begin
            beat_t b;
            b.x    = E'(i % W);
            b.y    = E'(i / W);
            b.d    = ram[i];
            b.last = (i == N - 1);
            exp_q.push_back(b);
`ifdef CHECKERBOARD_READER_COUNT_EN
            if (ram[i] == DB'(1)) exp_black++;
            if (ram[i] == DB'(2)) exp_white++;
`endif
        end
    endtask

    task automatic run_scan(input bit chk_latency, input bit extra_start);
        int cyc;
        load_model();
        @(posedge clk);
        #1;
        done_cnt = 0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check_eq("busy_after_start", busy, 1);
        check_eq("valid_after_start", sif.valid, 0);
        cyc = 0;
        while (!done && cyc < 4000) begin
            start = extra_start && (cyc == 10 || cyc == 40);
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (chk_latency && cyc == 1) check_eq("first_beat_latency", sif.valid, 1);
        end
        start = 1'b0;
        check_eq("done_seen", done, 1);
        if (chk_latency) check_eq("done_latency", cyc, 65);
        check_eq("busy_at_done", busy, 0);
        check_eq("beats_remaining", exp_q.size(), 0);
        check_eq("cnt_black", cnt_black, exp_black);
        check_eq("cnt_white", cnt_white, exp_white);
        repeat (3) @(posedge clk);
        #1;
        check_eq("done_pulse_count", done_cnt, 1);
        check_eq("cnt_black_hold", cnt_black, exp_black);
        check_eq("cnt_white_hold", cnt_white, exp_white);
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_valid"}, sif.valid, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_rd_addr"}, rd_addr, 0);
        check_eq({tag, "_x"}, sif.x, 0);
        check_eq({tag, "_y"}, sif.y, 0);
        check_eq({tag, "_data"}, sif.data, 0);
        check_eq({tag, "_last"}, sif.last, 0);
        check_eq({tag, "_cnt_black"}, cnt_black, 0);
        check_eq({tag, "_cnt_white"}, cnt_white, 0);
    endtask

    initial begin
        int b0;
        int c;
        for (int i = 0; i < N; i++) ram[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n       = 1'b1;
        ready_fixed = 1'b1;
        mon_en      = 1'b1;

        // Empty board, ready held high.
        run_scan(1'b1, 1'b0);

        // Sparse placements, including a reserved cell.
        ram[3 * W + 4] = 2'd1;
        ram[N - 1]     = 2'd2;
        ram[0]         = 2'd3;
        run_scan(1'b1, 1'b0);

        // Random board under random backpressure.
        for (int i = 0; i < N; i++) ram[i] = DB'($urandom_range(0, 3));
        rand_ready = 1'b1;
        run_scan(1'b0, 1'b0);
        rand_ready = 1'b0;

        // Start pulses while busy are ignored; a new board then rescans cleanly.
        run_scan(1'b1, 1'b1);
        for (int i = 0; i < N; i++) ram[i] = DB'($urandom_range(0, 3));
        run_scan(1'b1, 1'b0);

        // Reset in the middle of a scan.
        load_model();
        b0 = beats_acc;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c = 0;
        while (beats_acc < b0 + 20 && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        check_eq("reset_test_beats_reached", beats_acc - b0, 20);
        rst_n    = 1'b0;
        mon_en   = 1'b0;
        done_cnt = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_idle_outputs("midscan_reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("no_done_after_abort", done_cnt, 0);
        run_scan(1'b1, 1'b0);

        // Fully occupied board of black stones.
        for (int i = 0; i < N; i++) ram[i] = 2'd1;
        run_scan(1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
